// File: rtl/dma_pkg.sv
// Shared constants and encodings for the DMA channel register file.
// Mode word layout: [7:6] transfer mode, [5] decrement, [4] auto-init, [3:2] transfer type, [1:0] channel.
package dma_pkg;

  localparam int unsigned MODE_AUTOINIT = 4;
  localparam int unsigned MODE_DEC      = 5;

  localparam logic REG_SEL_ADDR = 1'b0;
  localparam logic REG_SEL_CNT  = 1'b1;

  typedef enum logic [1:0] {
    XFER_VERIFY  = 2'b00,
    XFER_WRITE   = 2'b01,
    XFER_READ    = 2'b10,
    XFER_ILLEGAL = 2'b11
  } xfer_type_e;

  typedef enum logic [1:0] {
    XMODE_DEMAND  = 2'b00,
    XMODE_SINGLE  = 2'b01,
    XMODE_BLOCK   = 2'b10,
    XMODE_CASCADE = 2'b11
  } xfer_mode_e;

  // A one-byte register still needs a 1-bit pointer to stay a legal vector.
  function automatic int unsigned ptr_width(input int unsigned nbyte);
    return (nbyte > 1) ? $clog2(nbyte) : 1;
  endfunction

endpackage

// File: rtl/dma_channel_ctr.sv
// Per-channel base/current address and count registers with step and auto-init reload.
module dma_channel_ctr
  import dma_pkg::*;
#(
  parameter int unsigned REG_W = 16,
  localparam int unsigned NBYTE = REG_W / 8,
  localparam int unsigned PTR_W = ptr_width(NBYTE)
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             wr_addr,
  input  logic             wr_cnt,
  input  logic [PTR_W-1:0] ptr,
  input  logic [7:0]       data_in,
  input  logic             step,
  input  logic             dec,
  input  logic             autoinit,
  input  logic             eop_n,
  output logic [REG_W-1:0] cur_addr,
  output logic [REG_W-1:0] cur_cnt,
  output logic             tc_hit_c
);

  logic [REG_W-1:0] base_addr;
  logic [REG_W-1:0] base_cnt;

  // Terminal count: the count is about to roll over, or the device ends the block early.
  assign tc_hit_c = step && ((cur_cnt == '0) || !eop_n);

  always_ff @(posedge clk) begin
    if (RESET) begin
      base_addr <= '0;
      base_cnt  <= '0;
      cur_addr  <= '0;
      cur_cnt   <= '0;
    end else if (wr_addr || wr_cnt) begin
      for (int b = 0; b < int'(NBYTE); b++) begin
        if (ptr == PTR_W'(b)) begin
          if (wr_addr) begin
            base_addr[b*8 +: 8] <= data_in;
            cur_addr[b*8 +: 8]  <= data_in;
          end else begin
            base_cnt[b*8 +: 8] <= data_in;
            cur_cnt[b*8 +: 8]  <= data_in;
          end
        end
      end
    end else if (step) begin
      if (tc_hit_c && autoinit) begin
        cur_addr <= base_addr;
        cur_cnt  <= base_cnt;
      end else begin
        cur_addr <= dec ? (cur_addr - REG_W'(1)) : (cur_addr + REG_W'(1));
        cur_cnt  <= cur_cnt - REG_W'(1);
      end
    end
  end

endmodule

// File: rtl/dma_channel_regfile.sv
// DMA register file: CPU byte access, mode/mask/status registers and per-channel counters.
// The top owns the shared byte pointer, the read mux and the registered terminal-count pulse.
module dma_channel_regfile
  import dma_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned REG_W  = 16,
  localparam int unsigned CH_W  = $clog2(NUM_CH),
  localparam int unsigned NBYTE = REG_W / 8
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [CH_W:0]     reg_sel,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  input  logic              mode_wr,
  input  logic [7:0]        mode_data,
  input  logic              clr_ptr,
  input  logic              status_rd,
  input  logic [NUM_CH-1:0] mask_clr,
  input  logic              svc_step,
  input  logic [CH_W-1:0]   svc_ch,
  input  logic              eop_n,
  output logic [REG_W-1:0]  cur_addr,
  output logic [7:0]        mode_out,
  output logic [NUM_CH-1:0] mask,
  output logic [NUM_CH-1:0] status,
  output logic              tc
);

  localparam int unsigned PTR_W = ptr_width(NBYTE);

  logic [PTR_W-1:0]  ptr;
  logic [7:0]        mode_r [NUM_CH];
  logic [REG_W-1:0]  cur_addr_a [NUM_CH];
  logic [REG_W-1:0]  cur_cnt_a [NUM_CH];
  logic [NUM_CH-1:0] tc_hit;
  logic [NUM_CH-1:0] autoinit_v;
  logic [NUM_CH-1:0] mask_nxt;
  logic [NUM_CH-1:0] status_nxt;
  logic [CH_W-1:0]   sel_ch;
  logic              sel_cnt;
  logic [REG_W-1:0]  rd_word;
  logic [7:0]        rd_byte;

  assign sel_ch  = reg_sel[CH_W:1];
  assign sel_cnt = (reg_sel[0] == REG_SEL_CNT);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_hit;
    logic step;

    // A CPU write to this channel discards a coincident transfer step.
    assign wr_hit = wr_en && (sel_ch == CH_W'(i));
    assign step   = svc_step && (svc_ch == CH_W'(i)) && !mask[i] && !wr_hit;
    assign autoinit_v[i] = mode_r[i][MODE_AUTOINIT];

    dma_channel_ctr #(.REG_W(REG_W)) u_ctr (
      .clk      (clk),
      .RESET    (RESET),
      .wr_addr  (wr_hit && (reg_sel[0] == REG_SEL_ADDR)),
      .wr_cnt   (wr_hit && sel_cnt),
      .ptr      (ptr),
      .data_in  (data_in),
      .step     (step),
      .dec      (mode_r[i][MODE_DEC]),
      .autoinit (mode_r[i][MODE_AUTOINIT]),
      .eop_n    (eop_n),
      .cur_addr (cur_addr_a[i]),
      .cur_cnt  (cur_cnt_a[i]),
      .tc_hit_c (tc_hit[i])
    );
  end

  assign cur_addr = cur_addr_a[svc_ch];
  assign mode_out = mode_r[svc_ch];

  // Shared byte pointer; a simultaneous write and read advance it once.
  always_ff @(posedge clk) begin
    if (RESET) begin
      ptr <= '0;
    end else if (clr_ptr) begin
      ptr <= '0;
    end else if (wr_en || rd_en) begin
      ptr <= (ptr == PTR_W'(NBYTE - 1)) ? '0 : (ptr + PTR_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (RESET) begin
        mode_r[i] <= '0;
      end else if (mode_wr && (mode_data[CH_W-1:0] == CH_W'(i))) begin
        mode_r[i] <= mode_data;
      end
    end
  end

  // Terminal-count sets win over mask clears, status reads and count-write clears.
  always_comb begin
    mask_nxt   = mask & ~mask_clr;
    status_nxt = status_rd ? '0 : status;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (wr_en && sel_cnt && (sel_ch == CH_W'(i)) && (ptr == PTR_W'(NBYTE - 1))) begin
        status_nxt[i] = 1'b0;
      end
    end
    mask_nxt   = mask_nxt | (tc_hit & ~autoinit_v);
    status_nxt = status_nxt | tc_hit;
  end

  always_comb begin
    rd_word = sel_cnt ? cur_cnt_a[sel_ch] : cur_addr_a[sel_ch];
    rd_byte = 8'(rd_word >> (8 * int'(ptr)));
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      mask     <= '1;
      status   <= '0;
      tc       <= 1'b0;
      data_out <= '0;
    end else begin
      mask   <= mask_nxt;
      status <= status_nxt;
      tc     <= |tc_hit;
      if (rd_en && !wr_en) begin
        data_out <= rd_byte;
      end
    end
  end

endmodule

// File: tb/tb_dma_channel_regfile.sv
// Directed bench for dma_channel_regfile: byte access, stepping, terminal count, collisions, reset.
module tb_dma_channel_regfile;

  logic        clk = 1'b0;
  logic        RESET;
  logic        wr_en, rd_en;
  logic [2:0]  reg_sel;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        mode_wr;
  logic [7:0]  mode_data;
  logic        clr_ptr, status_rd;
  logic [3:0]  mask_clr;
  logic        svc_step;
  logic [1:0]  svc_ch;
  logic        eop_n;
  logic [15:0] cur_addr;
  logic [7:0]  mode_out;
  logic [3:0]  mask, status;
  logic        tc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dma_channel_regfile #(.NUM_CH(4), .REG_W(16)) dut (
    .clk(clk), .RESET(RESET), .wr_en(wr_en), .rd_en(rd_en), .reg_sel(reg_sel),
    .data_in(data_in), .data_out(data_out), .mode_wr(mode_wr), .mode_data(mode_data),
    .clr_ptr(clr_ptr), .status_rd(status_rd), .mask_clr(mask_clr), .svc_step(svc_step),
    .svc_ch(svc_ch), .eop_n(eop_n), .cur_addr(cur_addr), .mode_out(mode_out),
    .mask(mask), .status(status), .tc(tc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; rd_en = 0; mode_wr = 0; clr_ptr = 0; status_rd = 0;
    mask_clr = '0; svc_step = 0; eop_n = 1;
  endtask

  task automatic wr_byte(input logic [2:0] sel, input logic [7:0] d);
    wr_en = 1; reg_sel = sel; data_in = d;
    tick();
    wr_en = 0;
  endtask

  task automatic rd_byte(input logic [2:0] sel);
    rd_en = 1; reg_sel = sel;
    tick();
    rd_en = 0;
  endtask

  task automatic pulse_clr_ptr();
    clr_ptr = 1;
    tick();
    clr_ptr = 0;
  endtask

  task automatic load_ch(input logic [1:0] ch, input logic [15:0] a, input logic [15:0] c);
    pulse_clr_ptr();
    wr_byte({ch, 1'b0}, a[7:0]);
    wr_byte({ch, 1'b0}, a[15:8]);
    wr_byte({ch, 1'b1}, c[7:0]);
    wr_byte({ch, 1'b1}, c[15:8]);
  endtask

  task automatic set_mode(input logic [7:0] m);
    mode_wr = 1; mode_data = m;
    tick();
    mode_wr = 0;
  endtask

  task automatic unmask(input logic [3:0] m);
    mask_clr = m;
    tick();
    mask_clr = '0;
  endtask

  task automatic step(input logic [1:0] ch, input logic eop);
    svc_step = 1; svc_ch = ch; eop_n = eop;
    tick();
    svc_step = 0; eop_n = 1;
  endtask

  initial begin
    reg_sel = '0; data_in = '0; mode_data = '0; svc_ch = '0;
    idle();
    RESET = 1;
    repeat (2) tick();
    RESET = 0;
    tick();
    check_eq("rst_status", 32'(status), 32'h0);
    check_eq("rst_mask", 32'(mask), 32'hF);
    check_eq("rst_data_out", 32'(data_out), 32'h0);
    check_eq("rst_tc", 32'(tc), 32'h0);

    // Channel 1, increment, no auto-init
    load_ch(2'd1, 16'h1234, 16'h0002);
    set_mode(8'h01);
    unmask(4'b0010);
    svc_ch = 2'd1;
    check_eq("c1_loaded", 32'(cur_addr), 32'h1234);
    check_eq("c1_mode", 32'(mode_out), 32'h01);
    step(2'd1, 1'b1);
    check_eq("c1_s1_addr", 32'(cur_addr), 32'h1235);
    check_eq("c1_s1_tc", 32'(tc), 32'h0);
    step(2'd1, 1'b1);
    check_eq("c1_s2_addr", 32'(cur_addr), 32'h1236);
    check_eq("c1_s2_tc", 32'(tc), 32'h0);
    step(2'd1, 1'b1);
    check_eq("c1_s3_addr", 32'(cur_addr), 32'h1237);
    check_eq("c1_s3_tc", 32'(tc), 32'h1);
    check_eq("c1_s3_status", 32'(status[1]), 32'h1);
    check_eq("c1_s3_mask", 32'(mask[1]), 32'h1);
    tick();
    check_eq("c1_tc_drop", 32'(tc), 32'h0);
    step(2'd1, 1'b1);
    check_eq("c1_s4_ignored", 32'(cur_addr), 32'h1237);
    check_eq("c1_s4_tc", 32'(tc), 32'h0);

    // Channel 1 again with auto-init; the count write also clears status[1]
    load_ch(2'd1, 16'h1234, 16'h0002);
    check_eq("c1_status_clr", 32'(status[1]), 32'h0);
    set_mode(8'h11);
    unmask(4'b0010);
    step(2'd1, 1'b1);
    step(2'd1, 1'b1);
    check_eq("ai_s2_addr", 32'(cur_addr), 32'h1236);
    step(2'd1, 1'b1);
    check_eq("ai_reload_addr", 32'(cur_addr), 32'h1234);
    check_eq("ai_tc", 32'(tc), 32'h1);
    check_eq("ai_mask", 32'(mask[1]), 32'h0);
    check_eq("ai_status", 32'(status[1]), 32'h1);
    pulse_clr_ptr();
    rd_byte(3'b011);
    check_eq("ai_cnt_lo", 32'(data_out), 32'h02);
    rd_byte(3'b011);
    check_eq("ai_cnt_hi", 32'(data_out), 32'h00);
    step(2'd1, 1'b1);
    check_eq("ai_s4_addr", 32'(cur_addr), 32'h1235);

    // Channel 2, decrement, early end-of-process
    load_ch(2'd2, 16'h0000, 16'h0005);
    set_mode(8'h22);
    unmask(4'b0100);
    svc_ch = 2'd2;
    step(2'd2, 1'b0);
    check_eq("c2_addr", 32'(cur_addr), 32'hFFFF);
    check_eq("c2_tc", 32'(tc), 32'h1);
    check_eq("c2_status", 32'(status), 32'b0110);
    check_eq("c2_mask", 32'(mask), 32'b1101);

    // Byte-serial read of channel 1 address with pointer wrap
    pulse_clr_ptr();
    rd_byte(3'b010);
    check_eq("rd_lo", 32'(data_out), 32'h35);
    rd_byte(3'b010);
    check_eq("rd_hi", 32'(data_out), 32'h12);
    rd_byte(3'b010);
    check_eq("rd_wrap", 32'(data_out), 32'h35);
    tick();
    check_eq("rd_hold", 32'(data_out), 32'h35);

    // Write to channel 0 count collides with a step on channel 0
    unmask(4'b0001);
    svc_ch = 2'd0;
    pulse_clr_ptr();
    wr_en = 1; reg_sel = 3'b001; data_in = 8'h07;
    svc_step = 1; svc_ch = 2'd0;
    tick();
    wr_en = 0; svc_step = 0;
    check_eq("col_addr", 32'(cur_addr), 32'h0000);
    check_eq("col_tc", 32'(tc), 32'h0);
    wr_byte(3'b001, 8'h00);
    pulse_clr_ptr();
    rd_byte(3'b001);
    check_eq("col_cnt", 32'(data_out), 32'h07);

    // Terminal count in the same cycle as a status read
    status_rd = 1;
    step(2'd0, 1'b0);
    status_rd = 0;
    check_eq("srd_tc", 32'(tc), 32'h1);
    check_eq("srd_status", 32'(status), 32'b0001);
    check_eq("srd_mask", 32'(mask), 32'b1101);
    check_eq("srd_addr", 32'(cur_addr), 32'h0001);

    // Reset in the middle of a byte sequence
    svc_ch = 2'd3;
    pulse_clr_ptr();
    wr_byte(3'b110, 8'hAB);
    check_eq("mid_addr", 32'(cur_addr), 32'h00AB);
    RESET = 1; wr_en = 1; reg_sel = 3'b110; data_in = 8'hCD;
    tick();
    RESET = 0; wr_en = 0;
    check_eq("mrst_addr", 32'(cur_addr), 32'h0000);
    check_eq("mrst_mask", 32'(mask), 32'hF);
    check_eq("mrst_status", 32'(status), 32'h0);
    check_eq("mrst_tc", 32'(tc), 32'h0);
    check_eq("mrst_data_out", 32'(data_out), 32'h0);
    wr_byte(3'b110, 8'h5A);
    check_eq("mrst_ptr", 32'(cur_addr), 32'h005A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
